// File: rtl/dmem_pkg.sv
// Shared funct3 codes, FSM state type and lane helpers for the dmem load/store unit.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_CLEAR,
    S_IDLE,
    S_WAIT,
    S_RESP
  } dmem_state_t;

  function automatic logic [3:0] byte_en(input logic [2:0] funct3, input logic [1:0] lo);
    case (funct3)
      F3_B, F3_BU: byte_en = 4'b0001 << lo;
      F3_H, F3_HU: byte_en = lo[1] ? 4'b1100 : 4'b0011;
      F3_W:        byte_en = 4'b1111;
      default:     byte_en = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [2:0] funct3,
                                           input logic [1:0] lo);
    logic [7:0]  v_b;
    logic [15:0] v_h;
    v_b = 8'(word >> {lo, 3'b000});
    v_h = lo[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    load_ext = {{24{v_b[7]}}, v_b};
      F3_BU:   load_ext = {24'h0, v_b};
      F3_H:    load_ext = {{16{v_h[15]}}, v_h};
      F3_HU:   load_ext = {16'h0, v_h};
      default: load_ext = word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH_WORDS x 32 data storage: byte-lane write enables, registered read port.
module dmem_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          CLK,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  always_ff @(posedge CLK) begin
    for (int b = 0; b < 4; b++) begin
      if (i_we[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
    end
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store front end for the data memory: valid/ready requests, wait states, faults, clear-on-reset.
// Build option: define DMEM_MISALIGN_TRAP_EN to fault misaligned H/HU/W accesses instead of aligning them down.
//
// state   | meaning
// S_CLEAR | zeroing the array one word per cycle after reset
// S_IDLE  | req_ready high, waiting for a request
// S_WAIT  | counting wait states before commit
// S_RESP  | response held until rsp_ready
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter int          LATENCY     = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN      = 32'(4 * DEPTH_WORDS);
  localparam bit          ZERO_LAT  = (LATENCY == 0);
  localparam logic [3:0]  WAIT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  dmem_state_t   r_state;
  logic [AW-1:0] r_clr_cnt;
  logic [3:0]    r_wait_cnt;
  logic          r_req_ready;
  logic          r_rsp_valid;
  logic          r_rsp_fault;
  logic          r_rsp_load;
  logic          r_we;
  logic          r_fault;
  logic [2:0]    r_funct3;
  logic [1:0]    r_lo;
  logic [AW-1:0] r_idx;
  logic [3:0]    r_be;
  logic [31:0]   r_lanes;

  logic [31:0]   w_off;
  logic          w_in_range;
  logic          w_bad_f3;
  logic          w_is_half;
  logic          w_is_word;
  logic          w_d_fault;
  logic [1:0]    w_d_lo;
  logic [AW-1:0] w_d_idx;
  logic [3:0]    w_d_be;
  logic [31:0]   w_d_lanes;

  logic          w_accept;
  logic          w_commit;
  logic          w_c_we;
  logic          w_c_fault;
  logic [AW-1:0] w_c_idx;
  logic [3:0]    w_c_be;
  logic [31:0]   w_c_lanes;

  logic [3:0]    w_arr_we;
  logic [AW-1:0] w_arr_waddr;
  logic [31:0]   w_arr_wdata;
  logic          w_arr_re;
  logic [31:0]   w_arr_rdata;

  // Decode of the live request; only meaningful on the accept edge.
  always_comb begin
    w_off      = req_addr - BASE_ADDR;
    w_in_range = (w_off < SPAN);
    w_bad_f3   = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111) ||
                 (req_we && ((req_funct3 == F3_BU) || (req_funct3 == F3_HU)));
    w_is_half  = (req_funct3 == F3_H) || (req_funct3 == F3_HU);
    w_is_word  = (req_funct3 == F3_W);
`ifdef DMEM_MISALIGN_TRAP_EN
    w_d_fault  = !w_in_range || w_bad_f3 ||
                 (w_is_half && w_off[0]) || (w_is_word && (w_off[1:0] != 2'b00));
    w_d_lo     = w_off[1:0];
`else
    w_d_fault  = !w_in_range || w_bad_f3;
    w_d_lo     = w_is_word ? 2'b00 : (w_is_half ? {w_off[1], 1'b0} : w_off[1:0]);
`endif
    w_d_idx    = w_off[AW+1:2];
    w_d_be     = byte_en(req_funct3, w_d_lo);
    case (req_funct3)
      F3_B, F3_BU: w_d_lanes = {4{req_wdata[7:0]}};
      F3_H, F3_HU: w_d_lanes = {2{req_wdata[15:0]}};
      default:     w_d_lanes = req_wdata;
    endcase
  end

  // With no wait states the commit uses the live request; otherwise the latched copy.
  always_comb begin
    w_accept  = (r_state == S_IDLE) && req_valid;
    w_commit  = RST && (ZERO_LAT ? w_accept : ((r_state == S_WAIT) && (r_wait_cnt == 4'd0)));
    w_c_we    = ZERO_LAT ? req_we    : r_we;
    w_c_fault = ZERO_LAT ? w_d_fault : r_fault;
    w_c_idx   = ZERO_LAT ? w_d_idx   : r_idx;
    w_c_be    = ZERO_LAT ? w_d_be    : r_be;
    w_c_lanes = ZERO_LAT ? w_d_lanes : r_lanes;

    if (r_state == S_CLEAR) begin
      w_arr_we    = 4'hF;
      w_arr_waddr = r_clr_cnt;
      w_arr_wdata = 32'h0;
    end else begin
      w_arr_we    = (w_commit && w_c_we && !w_c_fault) ? w_c_be : 4'h0;
      w_arr_waddr = w_c_idx;
      w_arr_wdata = w_c_lanes;
    end
    w_arr_re = w_commit && !w_c_we && !w_c_fault;
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .CLK    (CLK),
    .i_we   (w_arr_we),
    .i_waddr(w_arr_waddr),
    .i_wdata(w_arr_wdata),
    .i_re   (w_arr_re),
    .i_raddr(w_c_idx),
    .o_rdata(w_arr_rdata)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state     <= S_CLEAR;
      r_clr_cnt   <= '0;
      r_wait_cnt  <= 4'd0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_fault <= 1'b0;
      r_rsp_load  <= 1'b0;
      r_we        <= 1'b0;
      r_fault     <= 1'b0;
      r_funct3    <= 3'b000;
      r_lo        <= 2'b00;
      r_idx       <= '0;
      r_be        <= 4'h0;
      r_lanes     <= 32'h0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_clr_cnt <= r_clr_cnt + 1'b1;
          if (r_clr_cnt == AW'(DEPTH_WORDS - 1)) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
          end
        end
        S_IDLE: begin
          if (req_valid) begin
            r_we        <= req_we;
            r_fault     <= w_d_fault;
            r_funct3    <= req_funct3;
            r_lo        <= w_d_lo;
            r_idx       <= w_d_idx;
            r_be        <= w_d_be;
            r_lanes     <= w_d_lanes;
            r_req_ready <= 1'b0;
            r_rsp_load  <= 1'b0;
            if (ZERO_LAT) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_fault <= w_c_fault;
              r_rsp_load  <= !w_c_we && !w_c_fault;
            end else begin
              r_state    <= S_WAIT;
              r_wait_cnt <= WAIT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (r_wait_cnt == 4'd0) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_fault <= r_fault;
            r_rsp_load  <= !r_we && !r_fault;
          end else begin
            r_wait_cnt <= r_wait_cnt - 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
          end
        end
        default: r_state <= S_CLEAR;
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_fault = r_rsp_fault;
  // Array read register holds until the next load commit, so this stays stable in S_RESP.
  assign rsp_rdata = r_rsp_load ? load_ext(w_arr_rdata, r_funct3, r_lo) : 32'h0;

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu against a byte-level memory model.
module tb_dmem_lsu;

  localparam int          DEPTH = 256;
  localparam int          LAT   = 3;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_fault;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  longint unsigned m_mem [DEPTH];

  dmem_lsu #(
    .DEPTH_WORDS(DEPTH),
    .LATENCY    (LAT),
    .BASE_ADDR  (BASE)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_funct3(req_funct3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_fault (rsp_fault)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int m_size(input int f3);
    if (f3 == 0 || f3 == 4) return 1;
    if (f3 == 1 || f3 == 5) return 2;
    return 4;
  endfunction

  function automatic bit m_fault(input bit we, input int f3, input logic [31:0] addr);
    bit f;
    longint a;
    a = longint'(addr);
    f = (a < longint'(BASE)) || (a >= longint'(BASE) + 4 * DEPTH);
    if (f3 == 3 || f3 == 6 || f3 == 7) f = 1;
    if (we && (f3 == 4 || f3 == 5)) f = 1;
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((f3 == 1 || f3 == 5) && (a % 2) != 0) f = 1;
    if (f3 == 2 && (a % 4) != 0) f = 1;
`endif
    return f;
  endfunction

  function automatic logic [31:0] m_load(input int f3, input logic [31:0] addr);
    longint unsigned w, v, lim;
    int sz, off;
    if (m_fault(0, f3, addr)) return 32'h0;
    w   = m_mem[(addr - BASE) / 4];
    sz  = m_size(f3);
    off = int'(addr % 4);
    off = off - (off % sz);
    lim = 64'd1 << (8 * sz);
    v   = (w >> (8 * off)) % lim;
    if (f3 < 4 && sz < 4 && v >= (lim / 2)) v = v + 64'h1_0000_0000 - lim;
    return v[31:0];
  endfunction

  function automatic void m_store(input int f3, input logic [31:0] addr, input logic [31:0] wd);
    longint unsigned w, b;
    int sz, off, idx, sh;
    if (m_fault(1, f3, addr)) return;
    idx = int'((addr - BASE) / 4);
    w   = m_mem[idx];
    sz  = m_size(f3);
    off = int'(addr % 4);
    off = off - (off % sz);
    for (int k = 0; k < sz; k++) begin
      b  = (longint'(wd) >> (8 * k)) & 64'hFF;
      sh = 8 * (off + k);
      w  = (w & ~(64'hFF << sh)) | (b << sh);
    end
    m_mem[idx] = w & 64'hFFFF_FFFF;
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
  endfunction

  // ---------------- transaction driver ----------------
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic flt,
                        output int lat, output int acc);
    int n;
    rd  = 32'h0;
    flt = 1'b0;
    lat = -1;
    acc = -1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    req_valid  = 1'b1;
    n = 0;
    while (!req_ready && n < 2000) begin
      @(posedge CLK); #1; n++;
    end
    if (!req_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout: req_ready=%0b want 1", req_ready);
      req_valid = 1'b0;
      return;
    end
    @(posedge CLK); #1;
    acc = cyc;
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(posedge CLK); #1; n++;
    end
    if (!rsp_valid) begin
      total++; bad++;
      $display("FAIL rsp_timeout: rsp_valid=%0b want 1", rsp_valid);
      return;
    end
    lat = n;
    rd  = rsp_rdata;
    flt = rsp_fault;
    if (rsp_ready) begin
      @(posedge CLK); #1;
    end
  endtask

  task automatic pulse_reset(output int n);
    RST = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b1;
    m_clear();
    n = 0;
    while (!req_ready && n < 1000) begin
      @(posedge CLK); #1; n++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int n;
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_req_ready: got %0b want 0", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %0b want 0", rsp_valid); end
    total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
    total++; if (rsp_fault !== 1'b0) begin bad++; $display("FAIL reset_rsp_fault: got %0b want 0", rsp_fault); end
    RST = 1'b1;
    m_clear();
    n = 0;
    while (!req_ready && n < 1000) begin
      @(posedge CLK); #1; n++;
    end
    total++; if (n != DEPTH) begin bad++; $display("FAIL reset_clear_cycles: got %0d want %0d", n, DEPTH); end
  endtask

  task automatic test_subword();
    logic [31:0] rd; logic flt; int lat, acc;
    do_req(1, 3'b010, 32'h0, 32'h1122_3344, rd, flt, lat, acc); m_store(2, 32'h0, 32'h1122_3344);
    total++; if (flt !== 1'b0 || rd !== 32'h0) begin bad++; $display("FAIL sw_rsp: got fault=%0b rdata=%h want 0/0", flt, rd); end
    do_req(1, 3'b000, 32'h1, 32'h0000_00AB, rd, flt, lat, acc); m_store(0, 32'h1, 32'h0000_00AB);
    do_req(0, 3'b010, 32'h0, 32'h0, rd, flt, lat, acc);
    total++; if (rd !== 32'h1122_AB44) begin bad++; $display("FAIL lw_after_sb: got %h want 1122ab44", rd); end
    do_req(0, 3'b000, 32'h1, 32'h0, rd, flt, lat, acc);
    total++; if (rd !== 32'hFFFF_FFAB) begin bad++; $display("FAIL lb_sign: got %h want ffffffab", rd); end
    do_req(0, 3'b100, 32'h1, 32'h0, rd, flt, lat, acc);
    total++; if (rd !== 32'h0000_00AB) begin bad++; $display("FAIL lbu_zero: got %h want 000000ab", rd); end
    do_req(0, 3'b001, 32'h2, 32'h0, rd, flt, lat, acc);
    total++; if (rd !== 32'h0000_1122) begin bad++; $display("FAIL lh_upper: got %h want 00001122", rd); end
    do_req(0, 3'b101, 32'h0, 32'h0, rd, flt, lat, acc);
    total++; if (rd !== 32'h0000_AB44) begin bad++; $display("FAIL lhu_lower: got %h want 0000ab44", rd); end
  endtask

  task automatic test_random();
    logic [31:0] rd, addr, wd, exp_rd; logic flt, exp_flt, we; logic [2:0] f3; int lat, acc;
    for (int i = 0; i < 150; i++) begin
      we = 1'($urandom);
      f3 = 3'($urandom);
      wd = $urandom;
      if ($urandom_range(0, 9) == 0) addr = BASE + 32'(4 * DEPTH) + $urandom_range(0, 4095);
      else addr = BASE + $urandom_range(0, 127);
      exp_flt = m_fault(we, int'(f3), addr);
      exp_rd  = we ? 32'h0 : m_load(int'(f3), addr);
      do_req(we, f3, addr, wd, rd, flt, lat, acc);
      if (we) m_store(int'(f3), addr, wd);
      total++; if (flt !== exp_flt) begin bad++; $display("FAIL rand_fault[%0d] we=%0b f3=%0d a=%h: got %0b want %0b", i, we, f3, addr, flt, exp_flt); end
      total++; if (rd !== exp_rd) begin bad++; $display("FAIL rand_rdata[%0d] we=%0b f3=%0d a=%h: got %h want %h", i, we, f3, addr, rd, exp_rd); end
      total++; if (lat != LAT) begin bad++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, lat + 1, LAT + 1); end
    end
  endtask

  task automatic test_latency_backpressure();
    logic [31:0] rd, wd; logic flt; int lat, acc;
    wd = $urandom | 32'h8000_0001;
    do_req(1, 3'b010, 32'h20, wd, rd, flt, lat, acc); m_store(2, 32'h20, wd);
    rsp_ready = 1'b0;
    do_req(0, 3'b010, 32'h20, 32'h0, rd, flt, lat, acc);
    total++; if (lat != LAT) begin bad++; $display("FAIL bp_latency: got %0d want %0d", lat + 1, LAT + 1); end
    for (int k = 0; k < 5; k++) begin
      @(posedge CLK); #1;
      total++; if (rsp_valid !== 1'b1 || rsp_rdata !== wd || rsp_fault !== 1'b0 || req_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold[%0d]: got v=%0b d=%h f=%0b rdy=%0b want 1/%h/0/0", k, rsp_valid, rsp_rdata, rsp_fault, req_ready, wd);
      end
    end
    rsp_ready = 1'b1;
    @(posedge CLK); #1;
    total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin bad++; $display("FAIL bp_release: got v=%0b rdy=%0b want 0/1", rsp_valid, req_ready); end
  endtask

  task automatic test_faults();
    logic [31:0] rd; logic flt; int lat, acc;
    do_req(0, 3'b010, BASE + 32'h400, 32'h0, rd, flt, lat, acc);
    total++; if (flt !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL oor_load: got f=%0b d=%h want 1/0", flt, rd); end
    do_req(0, 3'b010, 32'hFFFF_FFFC, 32'h0, rd, flt, lat, acc);
    total++; if (flt !== 1'b1) begin bad++; $display("FAIL oor_high: got f=%0b want 1", flt); end
    do_req(1, 3'b010, 32'h30, 32'hCAFE_F00D, rd, flt, lat, acc); m_store(2, 32'h30, 32'hCAFE_F00D);
    do_req(1, 3'b100, 32'h30, 32'h1234_5678, rd, flt, lat, acc);
    total++; if (flt !== 1'b1) begin bad++; $display("FAIL store_bu: got f=%0b want 1", flt); end
    do_req(1, 3'b011, 32'h30, 32'h8765_4321, rd, flt, lat, acc);
    total++; if (flt !== 1'b1) begin bad++; $display("FAIL store_f3_011: got f=%0b want 1", flt); end
    do_req(0, 3'b010, 32'h30, 32'h0, rd, flt, lat, acc);
    total++; if (flt !== 1'b0 || rd !== 32'hCAFE_F00D) begin bad++; $display("FAIL mem_unchanged: got f=%0b d=%h want 0/cafef00d", flt, rd); end
    do_req(0, 3'b111, 32'h30, 32'h0, rd, flt, lat, acc);
    total++; if (flt !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL f3_111: got f=%0b d=%h want 1/0", flt, rd); end
  endtask

  task automatic test_misalign();
    logic [31:0] rd; logic flt; int lat, acc;
    logic        e_flt;
    logic [31:0] e_lw, e_lh, e_word;
`ifdef DMEM_MISALIGN_TRAP_EN
    e_flt = 1'b1; e_lw = 32'h0; e_lh = 32'h0; e_word = 32'h89AB_CDEF;
`else
    e_flt = 1'b0; e_lw = 32'h89AB_CDEF; e_lh = 32'hFFFF_CDEF; e_word = 32'h5555_CDEF;
`endif
    do_req(1, 3'b010, 32'h4, 32'h89AB_CDEF, rd, flt, lat, acc); m_store(2, 32'h4, 32'h89AB_CDEF);
    do_req(0, 3'b010, 32'h6, 32'h0, rd, flt, lat, acc);
    total++; if (flt !== e_flt || rd !== e_lw) begin bad++; $display("FAIL misalign_lw: got f=%0b d=%h want %0b/%h", flt, rd, e_flt, e_lw); end
    do_req(0, 3'b001, 32'h5, 32'h0, rd, flt, lat, acc);
    total++; if (flt !== e_flt || rd !== e_lh) begin bad++; $display("FAIL misalign_lh: got f=%0b d=%h want %0b/%h", flt, rd, e_flt, e_lh); end
    do_req(1, 3'b001, 32'h7, 32'h0000_5555, rd, flt, lat, acc); m_store(1, 32'h7, 32'h0000_5555);
    total++; if (flt !== e_flt) begin bad++; $display("FAIL misalign_sh: got f=%0b want %0b", flt, e_flt); end
    do_req(0, 3'b010, 32'h4, 32'h0, rd, flt, lat, acc);
    total++; if (rd !== e_word) begin bad++; $display("FAIL misalign_word: got %h want %h", rd, e_word); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic flt; int lat; int acc [4];
    for (int i = 0; i < 4; i++) do_req(0, 3'b010, 32'(4 * i), 32'h0, rd, flt, lat, acc[i]);
    for (int i = 1; i < 4; i++) begin
      total++; if (acc[i] - acc[i-1] != LAT + 2) begin bad++; $display("FAIL b2b_spacing[%0d]: got %0d want %0d", i, acc[i] - acc[i-1], LAT + 2); end
    end
  endtask

  task automatic test_reset_clear();
    logic [31:0] rd; logic flt; int lat, acc, n, errs;
    for (int i = 0; i < 8; i++) begin
      rd = $urandom | 32'h1;
      do_req(1, 3'b010, 32'(4 * $urandom_range(0, DEPTH - 1)), rd, rd, flt, lat, acc);
    end
    do_req(1, 3'b010, 32'h3FC, 32'hFFFF_FFFF, rd, flt, lat, acc);
    pulse_reset(n);
    total++; if (n != DEPTH) begin bad++; $display("FAIL clear_cycles: got %0d want %0d", n, DEPTH); end
    errs = 0;
    for (int i = 0; i < DEPTH; i++) begin
      do_req(0, 3'b010, BASE + 32'(4 * i), 32'h0, rd, flt, lat, acc);
      total++; if (rd !== 32'h0 || flt !== 1'b0) begin
        bad++;
        if (errs < 8) $display("FAIL clear_word[%0d]: got d=%h f=%0b want 0/0", i, rd, flt);
        errs++;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic flt; int lat, acc, n; bit seen;
    req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'hDEAD_BEEF;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 100) begin @(posedge CLK); #1; n++; end
    @(posedge CLK); #1;
    req_valid = 1'b0;
    seen = rsp_valid;
    @(posedge CLK); #1;
    seen = seen | rsp_valid;
    RST = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b1;
    m_clear();
    n = 0;
    while (!req_ready && n < 1000) begin
      seen = seen | rsp_valid;
      @(posedge CLK); #1; n++;
    end
    total++; if (seen) begin bad++; $display("FAIL mid_reset_rsp: got rsp_valid=1 want never"); end
    total++; if (n != DEPTH) begin bad++; $display("FAIL mid_reset_clear: got %0d want %0d", n, DEPTH); end
    do_req(0, 3'b010, 32'h10, 32'h0, rd, flt, lat, acc);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL mid_reset_word: got %h want 0", rd); end
  endtask

  initial begin
    test_reset();
    test_subword();
    test_random();
    test_latency_backpressure();
    test_faults();
    test_misalign();
    test_back_to_back();
    test_reset_clear();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
